// File: rtl/buffer_escritura_reg_if.sv
// -----------------------------------------------------------------------------
// buffer_escritura_reg_if
// Bundles the write-back buffer's producer, register-file and bypass signals.
//   Alu*     : ALU result handshake (AluValid/AluReg/AluData in, AluReady out)
//   Mem*     : load result handshake (MemValid/MemReg/MemData in, MemReady out)
//   Stall    : register file busy, holds the drain
//   Write*   : register file write port (WriteReg/WriteData/Regwrite)
//   Lookup*  : bypass query (LookupReg in, LookupHit/LookupData out)
//   Count/Full/Empty : FIFO occupancy status
// Modports: master = pipeline/register-file side, slave = the buffer.
// -----------------------------------------------------------------------------
interface buffer_escritura_reg_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2
);
    logic              AluValid;
    logic [4:0]        AluReg;
    logic [DATA_W-1:0] AluData;
    logic              AluReady;
    logic              MemValid;
    logic [4:0]        MemReg;
    logic [DATA_W-1:0] MemData;
    logic              MemReady;
    logic              Stall;
    logic [4:0]        WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic              Regwrite;
    logic [4:0]        LookupReg;
    logic              LookupHit;
    logic [DATA_W-1:0] LookupData;
    logic [ADDR_W:0]   Count;
    logic              Full;
    logic              Empty;

    modport master (
        output AluValid, AluReg, AluData, MemValid, MemReg, MemData, Stall, LookupReg,
        input  AluReady, MemReady, WriteReg, WriteData, Regwrite, LookupHit, LookupData,
               Count, Full, Empty
    );

    modport slave (
        input  AluValid, AluReg, AluData, MemValid, MemReg, MemData, Stall, LookupReg,
        output AluReady, MemReady, WriteReg, WriteData, Regwrite, LookupHit, LookupData,
               Count, Full, Empty
    );
endinterface

// File: rtl/buffer_escritura_reg.sv
// -----------------------------------------------------------------------------
// buffer_escritura_reg
// Write-back buffer: accepts ALU and load results into a small in-order FIFO
// and drains one entry per cycle onto the register file write port. A bypass
// lookup lets decode see values still queued or in the output register.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : buffer_escritura_reg_if.slave (handshakes, write port, lookup, status)
// Optional feature: define WB_BYPASS_EN to build the lookup search; otherwise
// LookupHit/LookupData are tied to zero.
// -----------------------------------------------------------------------------
module buffer_escritura_reg #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32
) (
    input  logic clk,
    input  logic rst,
    buffer_escritura_reg_if.slave bus
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

    logic [ADDR_W-1:0] head, tail, aluSlot;
    logic [ADDR_W:0]   count, freeSlots;
    logic [DEPTH-1:0]  entryValid;
    logic [4:0]        regMem  [DEPTH];
    logic [DATA_W-1:0] dataMem [DEPTH];
    logic              regwrite;
    logic [4:0]        writeReg;
    logic [DATA_W-1:0] writeData;
    logic              memPush, aluPush, pop;

    // Credit is taken from the registered count only; a pop this cycle does
    // not free a slot for this cycle's producers.
    assign freeSlots    = DEPTH_C - count;
    assign bus.MemReady = (freeSlots != '0);
    assign bus.AluReady = (freeSlots > ONE_C) | ((freeSlots != '0) & ~bus.MemValid);

    // Destination 0 completes the handshake but is dropped.
    assign memPush = bus.MemValid & bus.MemReady & (bus.MemReg != 5'd0);
    assign aluPush = bus.AluValid & bus.AluReady & (bus.AluReg != 5'd0);
    // Load is the older instruction, so it takes the tail slot first.
    assign aluSlot = memPush ? tail + ADDR_W'(1) : tail;
    assign pop     = (count != '0) & ~bus.Stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            entryValid <= '0;
            regwrite   <= 1'b0;
            writeReg   <= 5'd0;
            writeData  <= '0;
        end else begin
            if (pop) begin
                head             <= head + ADDR_W'(1);
                entryValid[head] <= 1'b0;
                regwrite         <= 1'b1;
                writeReg         <= regMem[head];
                writeData        <= dataMem[head];
            end else begin
                regwrite <= 1'b0;
            end
            if (memPush) entryValid[tail]    <= 1'b1;
            if (aluPush) entryValid[aluSlot] <= 1'b1;
            tail  <= tail + ADDR_W'(memPush) + ADDR_W'(aluPush);
            count <= count + (ADDR_W+1)'(memPush) + (ADDR_W+1)'(aluPush)
                           - (ADDR_W+1)'(pop);
        end
    end

    // Entry storage carries no reset; occupancy is tracked by entryValid.
    always_ff @(posedge clk) begin
        if (memPush) begin
            regMem[tail]  <= bus.MemReg;
            dataMem[tail] <= bus.MemData;
        end
        if (aluPush) begin
            regMem[aluSlot]  <= bus.AluReg;
            dataMem[aluSlot] <= bus.AluData;
        end
    end

    assign bus.Regwrite  = regwrite;
    assign bus.WriteReg  = writeReg;
    assign bus.WriteData = writeData;
    assign bus.Count     = count;
    assign bus.Full      = (count == DEPTH_C);
    assign bus.Empty     = (count == '0);

`ifdef WB_BYPASS_EN
    logic              lookupHit;
    logic [DATA_W-1:0] lookupData;
    logic [ADDR_W-1:0] idx;

    // Output register has lowest priority; queue entries are then scanned
    // oldest to newest so the newest match overwrites earlier ones.
    always_comb begin
        lookupHit  = 1'b0;
        lookupData = '0;
        idx        = head;
        if (bus.LookupReg != 5'd0) begin
            if (regwrite && (writeReg == bus.LookupReg)) begin
                lookupHit  = 1'b1;
                lookupData = writeData;
            end
            for (int i = 0; i < DEPTH; i++) begin
                idx = head + ADDR_W'(i);
                if (entryValid[idx] && (regMem[idx] == bus.LookupReg)) begin
                    lookupHit  = 1'b1;
                    lookupData = dataMem[idx];
                end
            end
        end
    end

    assign bus.LookupHit  = lookupHit;
    assign bus.LookupData = lookupData;
`else
    logic unusedLookup;
    assign unusedLookup   = ^{bus.LookupReg, entryValid};
    assign bus.LookupHit  = 1'b0;
    assign bus.LookupData = '0;
`endif

endmodule

// File: tb/tb_buffer_escritura_reg.sv
// -----------------------------------------------------------------------------
// tb_buffer_escritura_reg
// Directed bench for buffer_escritura_reg with a queue-based reference model
// and a per-cycle compare process, plus literal expectations for each scenario.
// -----------------------------------------------------------------------------
module tb_buffer_escritura_reg;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    buffer_escritura_reg_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    buffer_escritura_reg #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int nChecks = 0;
    int nFail   = 0;
    bit cmpEn   = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]        r;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t              q[$];
    logic              mRegwrite;
    logic [4:0]        mWReg;
    logic [DATA_W-1:0] mWData;

    always @(posedge clk or posedge rst) begin
        int  free;
        bit  memAcc, aluAcc;
        ent_t e;
        if (rst) begin
            q.delete();
            mRegwrite <= 1'b0;
            mWReg     <= 5'd0;
            mWData    <= '0;
        end else begin
            free   = DEPTH - q.size();
            memAcc = bus.MemValid && (free >= 1);
            aluAcc = bus.AluValid && ((free >= 2) || (free >= 1 && !bus.MemValid));
            if (q.size() > 0 && !bus.Stall) begin
                mRegwrite <= 1'b1;
                mWReg     <= q[0].r;
                mWData    <= q[0].d;
                void'(q.pop_front());
            end else begin
                mRegwrite <= 1'b0;
            end
            if (memAcc && bus.MemReg != 0) begin
                e.r = bus.MemReg; e.d = bus.MemData; q.push_back(e);
            end
            if (aluAcc && bus.AluReg != 0) begin
                e.r = bus.AluReg; e.d = bus.AluData; q.push_back(e);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        int                free;
        logic              expHit;
        logic [DATA_W-1:0] expData;
        if (cmpEn && !rst) begin
            free = DEPTH - q.size();
            chk("Count",     64'(bus.Count),     64'(q.size()));
            chk("Empty",     64'(bus.Empty),     64'(q.size() == 0));
            chk("Full",      64'(bus.Full),      64'(q.size() == DEPTH));
            chk("MemReady",  64'(bus.MemReady),  64'(free >= 1));
            chk("AluReady",  64'(bus.AluReady),  64'((free >= 2) || (free >= 1 && !bus.MemValid)));
            chk("Regwrite",  64'(bus.Regwrite),  64'(mRegwrite));
            chk("WriteReg",  64'(bus.WriteReg),  64'(mWReg));
            chk("WriteData", 64'(bus.WriteData), 64'(mWData));
            expHit  = 1'b0;
            expData = '0;
`ifdef WB_BYPASS_EN
            if (bus.LookupReg != 0) begin
                for (int i = q.size() - 1; i >= 0 && !expHit; i--) begin
                    if (q[i].r == bus.LookupReg) begin
                        expHit = 1'b1; expData = q[i].d;
                    end
                end
                if (!expHit && mRegwrite && mWReg == bus.LookupReg) begin
                    expHit = 1'b1; expData = mWData;
                end
            end
`endif
            chk("LookupHit",  64'(bus.LookupHit),  64'(expHit));
            chk("LookupData", 64'(bus.LookupData), 64'(expData));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.AluValid = 1'b0; bus.AluReg = 5'd0; bus.AluData = '0;
        bus.MemValid = 1'b0; bus.MemReg = 5'd0; bus.MemData = '0;
    endtask

    task automatic pushBoth(input logic [4:0] mr, input logic [31:0] md,
                            input logic [4:0] ar, input logic [31:0] ad);
        bus.MemValid = 1'b1; bus.MemReg = mr; bus.MemData = md;
        bus.AluValid = 1'b1; bus.AluReg = ar; bus.AluData = ad;
    endtask

    logic expBypass;

    initial begin
`ifdef WB_BYPASS_EN
        expBypass = 1'b1;
`else
        expBypass = 1'b0;
`endif
        rst = 1'b1;
        idle();
        bus.Stall = 1'b0;
        bus.LookupReg = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_Count",    64'(bus.Count),     64'd0);
        chk("rst_Empty",    64'(bus.Empty),     64'd1);
        chk("rst_Full",     64'(bus.Full),      64'd0);
        chk("rst_Regwrite", 64'(bus.Regwrite),  64'd0);
        chk("rst_WriteReg", 64'(bus.WriteReg),  64'd0);
        chk("rst_WriteData",64'(bus.WriteData), 64'd0);
        rst   = 1'b0;
        cmpEn = 1'b1;
        tick();

        // single ALU write: accept at edge N, write visible after edge N+1
        bus.AluValid = 1'b1; bus.AluReg = 5'd5; bus.AluData = 32'h12345678;
        bus.LookupReg = 5'd5;
        tick();
        idle();
        chk("single_Count", 64'(bus.Count), 64'd1);
        chk("single_HitQ",  64'(bus.LookupHit), 64'(expBypass));
        tick();
        chk("single_Regwrite",  64'(bus.Regwrite),  64'd1);
        chk("single_WriteReg",  64'(bus.WriteReg),  64'd5);
        chk("single_WriteData", 64'(bus.WriteData), 64'h12345678);
        tick();
        chk("single_RegwriteOff", 64'(bus.Regwrite), 64'd0);
        chk("single_HoldReg",     64'(bus.WriteReg), 64'd5);

        // dual push: load first, then ALU
        pushBoth(5'd3, 32'hAAAA0000, 5'd4, 32'h0000BBBB);
        #1;
        chk("dual_MemReady", 64'(bus.MemReady), 64'd1);
        chk("dual_AluReady", 64'(bus.AluReady), 64'd1);
        tick();
        idle();
        chk("dual_Count", 64'(bus.Count), 64'd2);
        tick();
        chk("dual_first_Reg",   64'(bus.WriteReg),  64'd3);
        chk("dual_first_Data",  64'(bus.WriteData), 64'hAAAA0000);
        tick();
        chk("dual_second_Reg",  64'(bus.WriteReg),  64'd4);
        chk("dual_second_Data", 64'(bus.WriteData), 64'h0000BBBB);
        chk("dual_second_Wr",   64'(bus.Regwrite),  64'd1);
        tick();

        // $0 discard
        bus.AluValid = 1'b1; bus.AluReg = 5'd0; bus.AluData = 32'hFFFFFFFF;
        bus.LookupReg = 5'd0;
        #1;
        chk("zero_AluReady", 64'(bus.AluReady), 64'd1);
        tick();
        idle();
        chk("zero_Count", 64'(bus.Count), 64'd0);
        chk("zero_Hit",   64'(bus.LookupHit), 64'd0);
        tick();
        chk("zero_Regwrite", 64'(bus.Regwrite), 64'd0);

        // full under stall, then drain in order
        bus.Stall = 1'b1;
        pushBoth(5'd10, 32'h0000000A, 5'd11, 32'h0000000B);
        tick();
        pushBoth(5'd12, 32'h0000000C, 5'd13, 32'h0000000D);
        tick();
        pushBoth(5'd14, 32'h0000000E, 5'd15, 32'h0000000F);
        #1;
        chk("full_Full",     64'(bus.Full),     64'd1);
        chk("full_Count",    64'(bus.Count),    64'd4);
        chk("full_MemReady", 64'(bus.MemReady), 64'd0);
        chk("full_AluReady", 64'(bus.AluReady), 64'd0);
        tick();
        idle();
        bus.Stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("drain_Regwrite", 64'(bus.Regwrite), 64'd1);
            chk("drain_Reg",      64'(bus.WriteReg), 64'(10 + k));
        end
        chk("drain_Empty", 64'(bus.Empty), 64'd1);
        tick();
        chk("drain_RegwriteOff", 64'(bus.Regwrite), 64'd0);

        // bypass: newest of duplicate destinations wins
        bus.Stall = 1'b1;
        bus.AluValid = 1'b1; bus.AluReg = 5'd7; bus.AluData = 32'h1;
        tick();
        bus.AluData = 32'h2;
        tick();
        idle();
        bus.LookupReg = 5'd7;
        #1;
        chk("byp_Hit7",  64'(bus.LookupHit),  64'(expBypass));
        chk("byp_Data7", 64'(bus.LookupData), expBypass ? 64'h2 : 64'h0);
        bus.LookupReg = 5'd8;
        #1;
        chk("byp_Hit8",  64'(bus.LookupHit),  64'd0);
        chk("byp_Data8", 64'(bus.LookupData), 64'd0);
        bus.LookupReg = 5'd7;
        bus.Stall = 1'b0;
        tick();
        chk("byp_inflight_Data", 64'(bus.LookupData), expBypass ? 64'h2 : 64'h0);
        tick();
        chk("byp_outreg_Hit",  64'(bus.LookupHit),  64'(expBypass));
        chk("byp_outreg_Data", 64'(bus.LookupData), expBypass ? 64'h2 : 64'h0);
        tick();
        chk("byp_gone_Hit", 64'(bus.LookupHit), 64'd0);

        // mixed traffic pattern, checked by the compare process
        for (int i = 0; i < 30; i++) begin
            bus.AluValid  = (i % 3 != 0);
            bus.AluReg    = 5'(i % 5);
            bus.AluData   = 32'(i) * 32'h01010101;
            bus.MemValid  = (i % 4 == 1);
            bus.MemReg    = 5'((i % 7) + 1);
            bus.MemData   = 32'hC0DE0000 + 32'(i);
            bus.Stall     = (i % 6 >= 4);
            bus.LookupReg = 5'(i % 5);
            tick();
        end
        idle();
        bus.Stall = 1'b0;
        repeat (8) tick();

        // reset mid-queue with a write in flight
        bus.Stall = 1'b1;
        pushBoth(5'd1, 32'h11, 5'd2, 32'h22);
        tick();
        pushBoth(5'd3, 32'h33, 5'd6, 32'h66);
        tick();
        idle();
        bus.Stall = 1'b0;
        tick();
        chk("pre_rst_Regwrite", 64'(bus.Regwrite), 64'd1);
        chk("pre_rst_Count",    64'(bus.Count),    64'd3);
        cmpEn = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_Count",    64'(bus.Count),    64'd0);
        chk("async_rst_Empty",    64'(bus.Empty),    64'd1);
        chk("async_rst_Regwrite", 64'(bus.Regwrite), 64'd0);
        chk("async_rst_WriteReg", 64'(bus.WriteReg), 64'd0);
        rst = 1'b0;
        cmpEn = 1'b1;
        repeat (3) tick();
        chk("post_rst_Regwrite", 64'(bus.Regwrite), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
